// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_t : arbiter sequencing states (IDLE -> ACCESS -> DONE)
//   req_id_t    : requester identifiers, CPU = 0, DMA = 1
//   CNT_W       : width of the access-latency down-counter
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker (purely combinational).
//   req        : request vector, bit 0 = CPU, bit 1 = DMA
//   last_grant : requester granted most recently
//   gnt_id     : chosen requester (meaningful when gnt_valid)
//   gnt_valid  : at least one request present
module rr_pick2
    import cpu_mem_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output req_id_t    gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_CPU;
        case (req)
            2'b01:   gnt_id = REQ_CPU;
            2'b10:   gnt_id = REQ_DMA;
            // Tie: favour whoever was not served last
            2'b11:   gnt_id = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
            default: gnt_id = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between the CPU controller and
// the DMA/debug loader. Level requests become fixed-latency accesses
// (MEM_LAT cycles of mem_en) followed by a one-cycle acknowledge.
//   clk, rst                 : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata    : CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack       : CPU read data register, completion pulse
//   cpu_stall                : cpu_req & ~cpu_ack
//   dma_req/we/addr/wdata    : DMA request (held until dma_ack)
//   dma_rdata, dma_ack       : DMA read data register, completion pulse
//   mem_en/we/addr/wdata     : memory control, stable for a whole access
//   mem_rdata                : memory read data, valid in last access cycle
// MEM_LAT legal range is 1..15.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t        r_state;
    req_id_t           r_last_grant;
    req_id_t           r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;

    req_id_t           w_gnt_id;
    logic              w_gnt_valid;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    rr_pick2 u_pick (
        .req        ({dma_req, cpu_req}),
        .last_grant (r_last_grant),
        .gnt_id     (w_gnt_id),
        .gnt_valid  (w_gnt_valid)
    );

    always_comb begin
        w_sel_we    = cpu_we;
        w_sel_addr  = cpu_addr;
        w_sel_wdata = cpu_wdata;
        if (w_gnt_id == REQ_DMA) begin
            w_sel_we    = dma_we;
            w_sel_addr  = dma_addr;
            w_sel_wdata = dma_wdata;
        end
    end

    // Address/data come straight from the latches so they cannot move
    // while an access is in flight.
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= REQ_DMA;
            r_owner      <= REQ_CPU;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            cpu_ack      <= 1'b0;
            dma_ack      <= 1'b0;
            cpu_rdata    <= '0;
            dma_rdata    <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner      <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_we         <= w_sel_we;
                        r_cnt        <= CNT_LOAD;
                        // Enables are registered, so raise them on entry
                        mem_en       <= 1'b1;
                        mem_we       <= w_sel_we;
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (!r_we) begin
                            if (r_owner == REQ_CPU) cpu_rdata <= mem_rdata;
                            else                    dma_rdata <= mem_rdata;
                        end
                        cpu_ack <= (r_owner == REQ_CPU);
                        dma_ack <= (r_owner == REQ_DMA);
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (memory array + per-requester read registers).
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 12;
    localparam int unsigned DW  = 16;
    localparam int          LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic          cpu_ack, dma_ack, cpu_stall, mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Second build with single-cycle latency
    logic          c1_req = 1'b0;
    logic [AW-1:0] c1_addr = '0;
    logic [DW-1:0] d1_cpu_rdata, d1_dma_rdata, d1_mem_wdata, d1_mem_rdata;
    logic          d1_cpu_ack, d1_cpu_stall, d1_dma_ack, d1_mem_en, d1_mem_we;
    logic [AW-1:0] d1_mem_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(d1_cpu_rdata), .cpu_ack(d1_cpu_ack), .cpu_stall(d1_cpu_stall),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(12'h000), .dma_wdata(16'h0000),
        .dma_rdata(d1_dma_rdata), .dma_ack(d1_dma_ack),
        .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .mem_rdata(d1_mem_rdata)
    );
    assign d1_mem_rdata = (d1_mem_addr == 12'hFFF) ? 16'hC0DE : 16'h0000;

    // Memory array seen by the main DUT
    bit   [DW-1:0] bmem [0:4095];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    assign mem_rdata = bmem[mem_addr];
    always @(posedge clk) begin
        if (pl_en) bmem[pl_addr] <= pl_data;
        else if (mem_en && mem_we) bmem[mem_addr] <= mem_wdata;
    end

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- Transaction-level reference model ----------------
    // t = cycles since grant (0 = idle); access occupies t=1..LAT, ack at LAT+1
    bit   [DW-1:0] mmem [0:4095];
    int            t;
    bit            own;        // 0 = CPU, 1 = DMA
    bit            lastg;
    bit            lwe;
    logic [AW-1:0] laddr;
    logic [DW-1:0] lwd;
    logic [DW-1:0] rd [2];

    initial begin
        forever begin
            @(negedge clk);
            if (pl_en) mmem[pl_addr] = pl_data;
            if (rst) begin
                chk("m_rst_en",    32'(mem_en),    32'd0);
                chk("m_rst_we",    32'(mem_we),    32'd0);
                chk("m_rst_cack",  32'(cpu_ack),   32'd0);
                chk("m_rst_dack",  32'(dma_ack),   32'd0);
                chk("m_rst_crd",   32'(cpu_rdata), 32'd0);
                chk("m_rst_drd",   32'(dma_rdata), 32'd0);
                chk("m_rst_stall", 32'(cpu_stall), 32'(cpu_req));
                t = 0; lastg = 1'b1; own = 1'b0; lwe = 1'b0;
                laddr = '0; lwd = '0; rd[0] = '0; rd[1] = '0;
            end else begin
                bit ex_en, ex_cack, ex_dack;
                ex_en   = (t >= 1) && (t <= LAT);
                ex_cack = (t == LAT + 1) && !own;
                ex_dack = (t == LAT + 1) && own;
                chk("m_mem_en",  32'(mem_en),    32'(ex_en));
                chk("m_mem_we",  32'(mem_we),    32'(ex_en && lwe));
                chk("m_cpu_ack", 32'(cpu_ack),   32'(ex_cack));
                chk("m_dma_ack", 32'(dma_ack),   32'(ex_dack));
                chk("m_cpu_rd",  32'(cpu_rdata), 32'(rd[0]));
                chk("m_dma_rd",  32'(dma_rdata), 32'(rd[1]));
                chk("m_stall",   32'(cpu_stall), 32'(cpu_req && !ex_cack));
                if (ex_en) begin
                    chk("m_mem_addr", 32'(mem_addr), 32'(laddr));
                    if (lwe) chk("m_mem_wdata", 32'(mem_wdata), 32'(lwd));
                end
                // advance to next cycle
                if (t == 0) begin
                    if (cpu_req || dma_req) begin
                        if (cpu_req && dma_req) own = (lastg == 1'b0);
                        else                    own = dma_req;
                        lastg = own;
                        lwe   = own ? dma_we    : cpu_we;
                        laddr = own ? dma_addr  : cpu_addr;
                        lwd   = own ? dma_wdata : cpu_wdata;
                        t = 1;
                    end
                end else if (t <= LAT) begin
                    if (t == LAT) begin
                        if (lwe) mmem[laddr] = lwd;
                        else     rd[own] = mmem[laddr];
                    end
                    t++;
                end else begin
                    t = 0;
                end
            end
        end
    end

    // ---------------- Directed helpers ----------------
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        cyc();
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        cpu_req = 1'b0; dma_req = 1'b0;
        cyc(); rst = 1'b1;
        cyc(); cyc(); rst = 1'b0;
    endtask

    task automatic xact(input bit who, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        if (!who) begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
        else      begin dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1; end
        for (int k = 0; k < 40 && !got; k++) begin
            cyc();
            if (!who && cpu_ack) begin got = 1'b1; cpu_req = 1'b0; end
            if (who && dma_ack)  begin got = 1'b1; dma_req = 1'b0; end
        end
        chk("xact_done", 32'(got), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ca, da, n, tmo;
        bit both;
        bit seq [6];

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en",  32'(mem_en),    32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack),   32'd0);
        chk("rst_dma_rd",  32'(dma_rdata), 32'd0);
        chk("rst_addr",    32'(mem_addr),  32'd0);
        rst = 1'b0;

        // Single CPU read
        preload(12'h010, 16'h1234);
        cpu_we = 1'b0; cpu_addr = 12'h010; cpu_req = 1'b1;
        cyc();
        chk("t1_en_c1",   32'(mem_en),   32'd1);
        chk("t1_addr_c1", 32'(mem_addr), 32'h010);
        cyc();
        chk("t1_en_c2",   32'(mem_en),   32'd1);
        chk("t1_ack_c2",  32'(cpu_ack),  32'd0);
        cyc();
        chk("t1_ack_c3",  32'(cpu_ack),   32'd1);
        chk("t1_rd_c3",   32'(cpu_rdata), 32'h1234);
        chk("t1_dack_c3", 32'(dma_ack),   32'd0);
        chk("t1_en_c3",   32'(mem_en),    32'd0);
        cpu_req = 1'b0;
        cyc();
        chk("t1_ack_c4",  32'(cpu_ack),   32'd0);

        // Simultaneous writes after reset: CPU first
        do_reset();
        cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 16'hBEEF;
        dma_we = 1'b1; dma_addr = 12'h021; dma_wdata = 16'h00FF;
        cpu_req = 1'b1; dma_req = 1'b1;
        ca = -1; da = -1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (cpu_ack) begin ca = k; cpu_req = 1'b0; end
            if (dma_ack) begin da = k; dma_req = 1'b0; end
        end
        chk("t2_cpu_ack_cyc", 32'(ca), 32'd3);
        chk("t2_dma_ack_cyc", 32'(da), 32'd7);
        chk("t2_mem_020", 32'(bmem[12'h020]), 32'hBEEF);
        chk("t2_mem_021", 32'(bmem[12'h021]), 32'h00FF);

        // Continuous contention: reads, both held high
        do_reset();
        cpu_we = 1'b0; dma_we = 1'b0;
        cpu_req = 1'b1; dma_req = 1'b1;
        n = 0; both = 1'b0;
        for (int k = 0; k < 80 && n < 6; k++) begin
            cyc();
            if (cpu_ack && dma_ack) both = 1'b1;
            if (cpu_ack) begin seq[n] = 1'b0; n++; end
            else if (dma_ack) begin seq[n] = 1'b1; n++; end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("t3_count", 32'(n), 32'd6);
        chk("t3_overlap", 32'(both), 32'd0);
        for (int i = 0; i < 6; i++) chk("t3_order", 32'(seq[i]), 32'(i % 2));
        chk("t3_cpu_rd", 32'(cpu_rdata), 32'hBEEF);
        chk("t3_dma_rd", 32'(dma_rdata), 32'h00FF);
        cyc();

        // Write isolation
        preload(12'h040, 16'hAAAA);
        xact(1'b1, 1'b0, 12'h040, 16'h0000);
        chk("t4_dma_rd_a", 32'(dma_rdata), 32'hAAAA);
        xact(1'b0, 1'b1, 12'h040, 16'h5555);
        chk("t4_dma_rd_b", 32'(dma_rdata), 32'hAAAA);
        chk("t4_cpu_rd",   32'(cpu_rdata), 32'hBEEF);
        cyc();
        chk("t4_mem_040",  32'(bmem[12'h040]), 32'h5555);

        // Reset mid-access
        preload(12'h050, 16'h7777);
        cpu_we = 1'b0; cpu_addr = 12'h050; cpu_req = 1'b1;
        cyc();
        chk("t5_en_c1", 32'(mem_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_en_rst",  32'(mem_en),  32'd0);
        chk("t5_ack_rst", 32'(cpu_ack), 32'd0);
        cyc();
        rst = 1'b0;
        ca = -1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (cpu_ack && ca < 0) begin ca = k; cpu_req = 1'b0; end
        end
        chk("t5_ack_cyc", 32'(ca), 32'd3);
        chk("t5_rd", 32'(cpu_rdata), 32'h7777);

        // MEM_LAT = 1 build
        c1_addr = 12'hFFF; c1_req = 1'b1;
        cyc();
        chk("t6_en_c1",   32'(d1_mem_en),   32'd1);
        chk("t6_addr_c1", 32'(d1_mem_addr), 32'hFFF);
        chk("t6_ack_c1",  32'(d1_cpu_ack),  32'd0);
        cyc();
        chk("t6_en_c2",   32'(d1_mem_en),    32'd0);
        chk("t6_ack_c2",  32'(d1_cpu_ack),   32'd1);
        chk("t6_rd_c2",   32'(d1_cpu_rdata), 32'hC0DE);
        chk("t6_dack_c2", 32'(d1_dma_ack),   32'd0);
        c1_req = 1'b0;
        cyc();
        chk("t6_ack_c3",  32'(d1_cpu_ack),   32'd0);

        // Randomized traffic, checked by the model every cycle
        for (int k = 0; k < 3000; k++) begin
            cyc();
            if (cpu_req && cpu_ack) cpu_req = 1'b0;
            else if (!cpu_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    cpu_req   = 1'b1;
                    cpu_we    = 1'($urandom_range(0, 1));
                    cpu_addr  = AW'($urandom_range(0, 15));
                    cpu_wdata = DW'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                cpu_addr  = AW'($urandom_range(0, 15));
                cpu_wdata = DW'($urandom);
            end
            if (dma_req && dma_ack) dma_req = 1'b0;
            else if (!dma_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    dma_req   = 1'b1;
                    dma_we    = 1'($urandom_range(0, 1));
                    dma_addr  = AW'($urandom_range(0, 15));
                    dma_wdata = DW'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                dma_addr  = AW'($urandom_range(0, 15));
                dma_wdata = DW'($urandom);
            end
        end
        // Let outstanding requests finish
        tmo = 0;
        while ((cpu_req || dma_req) && tmo < 40) begin
            cyc();
            if (cpu_ack) cpu_req = 1'b0;
            if (dma_ack) dma_req = 1'b0;
            tmo++;
        end
        chk("drain", 32'(cpu_req || dma_req), 32'd0);
        repeat (5) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
